// File: rtl/t03_mem_sequencer.sv
// Shares one memory bus port between instruction fetch and data load/store.
// Zero-wait bus: 3 cycles per plain instruction, 5 per load/store; bus_busy stalls wait states.
module t03_mem_sequencer #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic [ADDR_W-1:0] instr_addr_i,
   input  logic              data_read_i,
   input  logic              data_write_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   input  logic [3:0]        data_sel_i,
   input  logic              bus_busy_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic              bus_read_o,
   output logic              bus_write_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   output logic [3:0]        bus_sel_o,
   output logic              freeze_instr_o,
   output logic              pc_en_o,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              data_done_o,
   output logic              mem_error_o
);

   typedef enum logic [2:0] {
      S_FETCH, S_F_WAIT, S_EXEC, S_DATA, S_D_WAIT, S_HALT
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        sel_q, sel_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              rd_c, wr_c, frz_c, pc_c, done_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;
   logic [3:0]        sel_c;
   logic              timeout;

   assign timeout = bus_busy_i && (cnt_q == CNT_LAST);

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      rd_c    = 1'b0;
      wr_c    = 1'b0;
      frz_c   = 1'b1;
      pc_c    = 1'b0;
      done_c  = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
      sel_c   = '0;

      case (state_q)
         S_FETCH: begin
            rd_c    = 1'b1;
            addr_c  = instr_addr_i;
            sel_c   = 4'hF;
            cnt_d   = '0;
            state_d = S_F_WAIT;
         end
         S_F_WAIT: begin
            addr_c = instr_addr_i;
            sel_c  = 4'hF;
            if (!bus_busy_i) begin
               // Open the instruction holder for exactly the cycle the fetch data is valid.
               frz_c   = 1'b0;
               state_d = S_EXEC;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_EXEC: begin
            if (data_write_i) begin
               wr_d    = 1'b1;
               state_d = S_DATA;
            end else if (data_read_i) begin
               wr_d    = 1'b0;
               state_d = S_DATA;
            end else begin
               pc_c    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DATA: begin
            rd_c    = !wr_q;
            wr_c    = wr_q;
            addr_c  = data_addr_i;
            wdata_c = data_wdata_i;
            sel_c   = data_sel_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
            sel_d   = data_sel_i;
            cnt_d   = '0;
            state_d = S_D_WAIT;
         end
         S_D_WAIT: begin
            addr_c  = addr_q;
            wdata_c = wdata_q;
            sel_c   = sel_q;
            if (!bus_busy_i) begin
               done_c  = 1'b1;
               pc_c    = 1'b1;
               if (!wr_q) rdata_d = bus_rdata_i;
               state_d = S_FETCH;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // While reset is held the decoded outputs are forced to their idle values.
   assign bus_read_o     = nrst_i & rd_c;
   assign bus_write_o    = nrst_i & wr_c;
   assign bus_addr_o     = nrst_i ? addr_c : '0;
   assign bus_wdata_o    = nrst_i ? wdata_c : '0;
   assign bus_sel_o      = nrst_i ? sel_c : '0;
   assign freeze_instr_o = ~nrst_i | frz_c;
   assign pc_en_o        = nrst_i & pc_c;
   assign data_done_o    = nrst_i & done_c;
   assign data_rdata_o   = rdata_q;
   assign mem_error_o    = err_q;

endmodule
